axi_traffic_gen: RTL and testbench
==================================

AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 Parameter ADDR_W, default 16: AXI address width.
REQ-002 Parameter DATA_W, default 32: AXI data width; the size field is fixed at log2(DATA_W/8).
REQ-003 Parameter ID_W, default 4: AXI ID width.
REQ-004 Parameter TXN_ID, default 1: constant value driven on AWID and ARID.
REQ-005 Port aclk, input, 1: single clock; all logic samples on the rising edge.
REQ-006 Port areset, input, 1: reset, asynchronous and active-high.
REQ-007 Port start, input, 1: one-cycle request to run a single write-then-read test.
REQ-008 Port base_addr, input, ADDR_W: burst start address; bits [1:0] are forced to 0.
REQ-009 Port burst_len, input, 8: AXI LEN value, giving burst_len+1 beats.
REQ-010 Port seed, input, DATA_W: data pattern seed.
REQ-011 Port busy, output, 1: high while a test is in progress.
REQ-012 Port done, output, 1: sticky test-complete flag.
REQ-013 Port err_cnt, output, 8: count of read-back mismatches.
REQ-014 Port axi_m, axi_if master modport: AXI4 master connected directly to the axi_ram slave port.

Function
REQ-015 The block SHALL latch base_addr, burst_len and seed on start in IDLE; start is ignored while busy=1.
REQ-016 The FSM SHALL have states IDLE, AW, W, B, AR, R, FIN.
- Transitions: IDLE -start-> AW -AW hs-> W -last W hs-> B -B hs-> AR -AR hs-> R -last R hs-> FIN -> IDLE.
REQ-017 A handshake occurs when VALID and READY are both high in the same cycle; VALID SHALL stay high and payload stable until the handshake.
REQ-018 AW and AR SHALL carry addr=base_addr, len=burst_len, size=2, burst=INCR(2'b01) and id=TXN_ID.
REQ-019 Write beat k SHALL carry WDATA=seed+k (mod 2^DATA_W) and WSTRB all ones; WLAST is high exactly on k=burst_len.
REQ-020 Only one transaction SHALL be outstanding at a time; AW and W are never overlapped.
- WVALID rises the cycle after the AW handshake.
REQ-021 BREADY SHALL be high only in state B.
REQ-022 RREADY SHALL be high only in state R.
REQ-023 On each R handshake at beat k, the block SHALL compare RDATA with seed+k; a mismatch increments err_cnt.
REQ-024 RLAST mismatching k==burst_len SHALL also count as one error; both conditions on one beat count as one error.
REQ-025 err_cnt SHALL saturate at 255.
REQ-026 err_cnt SHALL clear on an accepted start.
REQ-027 Entering FIN SHALL set done=1 and busy=0 on the next edge.
REQ-028 done SHALL clear on the next accepted start.
REQ-029 busy SHALL be 1 from the cycle after an accepted start until FIN.
REQ-030 Boundary: burst_len=0 produces a single-beat burst with WLAST and RLAST on beat 0.
REQ-031 Boundary: burst_len=255 produces 256 beats; the beat counter is 8 bits and SHALL NOT wrap before the last beat.
REQ-032 Boundary: READY held low indefinitely SHALL stall the FSM with VALID held; there is no timeout.

Reset
REQ-033 On areset=1 the block SHALL asynchronously drive:
- state=IDLE;
- all VALID, BREADY and RREADY low;
- busy=0, done=0, err_cnt=0;
- beat counter=0.
REQ-034 Reset mid-burst SHALL abandon the transaction immediately; the slave is reset on the same signal.

Configuration
REQ-035 With AXI_TGEN_CHECK_EN defined, the compare logic of REQ-023 to REQ-026 SHALL be present.
REQ-036 Without AXI_TGEN_CHECK_EN, the read phase SHALL still run, but err_cnt SHALL be tied to 0 and no comparator is synthesised.

Structure
REQ-037 Package axi_tgen_pkg SHALL hold:
- the state enum tgen_state_e;
- constants BURST_INCR=2'b01 and SIZE_4B=3'd2.
REQ-038 The block SHALL have a single sub-module, axi_tgen_pattern: the combinational seed+k generator shared by the W and R paths.

Verification
REQ-039 seed=32'h1000, base=16'h0040, len=3 against axi_ram -> WDATA 1000..1003, WLAST on beat 3, err_cnt=0, done=1.
REQ-040 len=0, seed=32'hFFFFFFFF -> one beat with WDATA=FFFFFFFF, WLAST=RLAST=1, err_cnt=0.
REQ-041 Slave model corrupts RDATA on beat 2 of len=7 -> err_cnt=1 with AXI_TGEN_CHECK_EN defined, 0 without it.
REQ-042 AWREADY held low for 10 cycles -> AWVALID and AWADDR stay stable, and no WVALID is driven until the handshake.
REQ-043 areset pulsed during beat 5 of a len=15 write -> all outputs reach reset values immediately; a new start then completes with err_cnt=0.
REQ-044 start asserted while busy -> ignored; latched seed and len are unchanged.

Source files
------------

// File: rtl/axi_tgen_pkg.sv
// Shared types and AXI encodings for the single-burst write/read-back traffic generator.
package axi_tgen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StFin
  } tgen_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;

  // AXI SIZE encoding for a full-width beat.
  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle (single ID, no QoS/cache/prot/lock) with master and slave views.
interface axi_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_tgen_pattern.sv
// Data pattern generator: beat k of a burst carries seed + k, wrapping at DATA_W bits.
module axi_tgen_pattern #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] seed_i,
  input  logic [7:0]        beat_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = seed_i + DATA_W'(beat_i);

endmodule

// File: rtl/axi_traffic_gen.sv
// Runs one INCR write burst then reads it back and counts mismatches.
// Read-back comparison is built only when AXI_TGEN_CHECK_EN is defined.
module axi_traffic_gen
  import axi_tgen_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned TXN_ID = 1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        burst_len,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt,
  axi_if.master             axi_m
);

  localparam logic [2:0] AxSize = axi_size(DATA_W);

  tgen_state_e       state_q, state_d;
  logic [7:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] pat;
  logic              last_beat;
  logic              start_ok;

  // W and R phases never overlap, so one generator serves both.
  axi_tgen_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .seed_i (seed_q),
    .beat_i (beat_q),
    .data_o (pat)
  );

  assign last_beat = (beat_q == len_q);
  assign start_ok  = (state_q == StIdle) && start;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    len_d   = len_q;
    seed_d  = seed_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAw;
          addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
          len_d   = burst_len;
          seed_d  = seed;
          beat_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      StAw: begin
        if (axi_m.awready) begin
          state_d = StW;
          beat_d  = '0;
        end
      end
      StW: begin
        if (axi_m.wready) begin
          if (last_beat) begin
            state_d = StB;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      StB: begin
        if (axi_m.bvalid) state_d = StAr;
      end
      StAr: begin
        if (axi_m.arready) begin
          state_d = StR;
          beat_d  = '0;
        end
      end
      StR: begin
        if (axi_m.rvalid) begin
          if (last_beat) begin
            state_d = StFin;
            beat_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Channel outputs decode straight from the state register, so reset clears them at once.
  assign axi_m.awid    = ID_W'(TXN_ID);
  assign axi_m.awaddr  = addr_q;
  assign axi_m.awlen   = len_q;
  assign axi_m.awsize  = AxSize;
  assign axi_m.awburst = BURST_INCR;
  assign axi_m.awvalid = (state_q == StAw);

  assign axi_m.wdata   = pat;
  assign axi_m.wstrb   = '1;
  assign axi_m.wlast   = (state_q == StW) && last_beat;
  assign axi_m.wvalid  = (state_q == StW);

  assign axi_m.bready  = (state_q == StB);

  assign axi_m.arid    = ID_W'(TXN_ID);
  assign axi_m.araddr  = addr_q;
  assign axi_m.arlen   = len_q;
  assign axi_m.arsize  = AxSize;
  assign axi_m.arburst = BURST_INCR;
  assign axi_m.arvalid = (state_q == StAr);

  assign axi_m.rready  = (state_q == StR);

`ifdef AXI_TGEN_CHECK_EN
  logic [7:0] err_q, err_d;
  logic       beat_bad;

  // A bad data word and a misplaced RLAST on the same beat count once.
  assign beat_bad = (axi_m.rdata != pat) || (axi_m.rlast != last_beat);

  always_comb begin
    err_d = err_q;
    if (start_ok) begin
      err_d = '0;
    end else if ((state_q == StR) && axi_m.rvalid && beat_bad && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench for axi_traffic_gen with a behavioural AXI memory slave.
module tb_axi_traffic_gen;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
`ifdef AXI_TGEN_CHECK_EN
  localparam int ExpCorruptErr = 1;
`else
  localparam int ExpCorruptErr = 0;
`endif

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        burst_len = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              busy;
  logic              done;
  logic [7:0]        err_cnt;

  int checks = 0;
  int failures = 0;

  axi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  axi_traffic_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .TXN_ID (1)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .start     (start),
    .base_addr (base_addr),
    .burst_len (burst_len),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt),
    .axi_m     (axi)
  );

  always #5 aclk = ~aclk;

  // Behavioural slave: memory plus logs of every write beat and RLAST handshake.
  logic [31:0] mem [256];
  logic [31:0] wlog [512];
  logic        wlastlog [512];
  int          wcnt = 0;
  int          rlast_cnt = 0;
  logic        aw_hold = 1'b0;
  int          corrupt_beat = -1;
  logic        aw_seen = 1'b0;
  logic        ovl_viol = 1'b0;
  logic [7:0]  wr_idx = '0;
  logic [7:0]  rd_idx = '0;
  logic [7:0]  rbeat = '0;
  logic [7:0]  rlen = '0;
  logic        rd_act = 1'b0;
  logic        bvalid_q = 1'b0;

  always_comb begin
    axi.awready = !aw_hold;
    axi.wready  = 1'b1;
    axi.arready = 1'b1;
    axi.bvalid  = bvalid_q;
    axi.bid     = 4'd1;
    axi.bresp   = 2'b00;
    axi.rvalid  = rd_act;
    axi.rid     = 4'd1;
    axi.rresp   = 2'b00;
    axi.rlast   = rd_act && (rbeat == rlen);
    axi.rdata   = mem[rd_idx];
    if (rd_act && (corrupt_beat == int'(rbeat))) axi.rdata = mem[rd_idx] ^ 32'h0000_00FF;
  end

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      bvalid_q <= 1'b0;
      rd_act   <= 1'b0;
      aw_seen  <= 1'b0;
      rbeat    <= '0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        wr_idx  <= axi.awaddr[9:2];
        aw_seen <= 1'b1;
      end
      if (axi.wvalid && !aw_seen) ovl_viol <= 1'b1;
      if (axi.wvalid && axi.wready) begin
        mem[wr_idx]    <= axi.wdata;
        wr_idx         <= wr_idx + 8'd1;
        wlog[wcnt]     <= axi.wdata;
        wlastlog[wcnt] <= axi.wlast;
        wcnt           <= wcnt + 1;
        if (axi.wlast) begin
          bvalid_q <= 1'b1;
          aw_seen  <= 1'b0;
        end
      end
      if (bvalid_q && axi.bready) bvalid_q <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        rd_idx <= axi.araddr[9:2];
        rlen   <= axi.arlen;
        rbeat  <= '0;
        rd_act <= 1'b1;
      end
      if (rd_act && axi.rready) begin
        rd_idx <= rd_idx + 8'd1;
        rbeat  <= rbeat + 8'd1;
        if (rbeat == rlen) begin
          rd_act    <= 1'b0;
          rlast_cnt <= rlast_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] b, input logic [7:0] l, input logic [31:0] s);
    @(negedge aclk);
    base_addr = b;
    burst_len = l;
    seed      = s;
    start     = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  // Counts beats in the write log window that differ from seed+k or misplace WLAST.
  task automatic check_wlog(input string tag, input int w0, input int n, input logic [31:0] s);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] e;
      e = s + 32'(k);
      if (wlog[w0 + k] !== e || wlastlog[w0 + k] !== (k == n - 1)) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int w0;
    int r0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(negedge aclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}),
          64'd0);
    areset = 1'b0;

    // Basic burst; base low bits must be dropped.
    w0 = wcnt;
    r0 = rlast_cnt;
    do_start(16'h0043, 8'd3, 32'h0000_1000);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_awvalid", 64'(axi.awvalid), 64'd1);
    check("t1_awaddr", 64'(axi.awaddr), 64'h0040);
    check("t1_awlen", 64'(axi.awlen), 64'd3);
    check("t1_awsize_burst_id", 64'({axi.awsize, axi.awburst, axi.awid}), 64'({3'd2, 2'b01, 4'd1}));
    wait_done("t1_done");
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_wcount", 64'(wcnt - w0), 64'd4);
    check("t1_wdata3", 64'(wlog[w0 + 3]), 64'h1003);
    check_wlog("t1_wlog", w0, 4, 32'h0000_1000);
    check("t1_rlast", 64'(rlast_cnt - r0), 64'd1);
    check("t1_err", 64'(err_cnt), 64'd0);

    // Single-beat burst with wrapping seed.
    w0 = wcnt;
    r0 = rlast_cnt;
    do_start(16'h0040, 8'd0, 32'hFFFF_FFFF);
    check("t2_done_clr", 64'(done), 64'd0);
    wait_done("t2_done");
    check("t2_wcount", 64'(wcnt - w0), 64'd1);
    check("t2_wdata", 64'(wlog[w0]), 64'hFFFF_FFFF);
    check("t2_wlast", 64'(wlastlog[w0]), 64'd1);
    check("t2_rlast", 64'(rlast_cnt - r0), 64'd1);
    check("t2_err", 64'(err_cnt), 64'd0);

    // Corrupted read beat 2 of an 8-beat burst.
    corrupt_beat = 2;
    do_start(16'h0040, 8'd7, 32'h0000_0A00);
    wait_done("t3_done");
    check("t3_err", 64'(err_cnt), 64'(ExpCorruptErr));
    corrupt_beat = -1;

    // AWREADY stalled; a second start during the stall must be ignored.
    aw_hold = 1'b1;
    w0 = wcnt;
    do_start(16'h0080, 8'd2, 32'h0000_0055);
    for (int i = 0; i < 10; i++) begin
      check("t4_awvalid", 64'(axi.awvalid), 64'd1);
      check("t4_awaddr", 64'(axi.awaddr), 64'h0080);
      check("t4_wvalid", 64'(axi.wvalid), 64'd0);
      if (i == 3) begin
        base_addr = 16'h0000;
        burst_len = 8'd0;
        seed      = 32'h0000_DEAD;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge aclk);
    end
    check("t4_awlen_hold", 64'(axi.awlen), 64'd2);
    aw_hold = 1'b0;
    wait_done("t4_done");
    check("t4_wcount", 64'(wcnt - w0), 64'd3);
    check_wlog("t4_wlog", w0, 3, 32'h0000_0055);
    check("t4_err", 64'(err_cnt), 64'd0);

    // Reset pulsed while beat 5 of a 16-beat write is on the bus.
    w0 = wcnt;
    do_start(16'h0040, 8'd15, 32'h0000_0200);
    begin
      int n = 0;
      while ((wcnt - w0) < 5 && n < 100) begin
        @(negedge aclk);
        n++;
      end
    end
    check("t5_at_beat5", 64'(axi.wvalid && (axi.wdata == 32'h0000_0205)), 64'd1);
    areset = 1'b1;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done_err", 64'({done, err_cnt}), 64'd0);
    check("t5_rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}),
          64'd0);
    @(negedge aclk);
    areset = 1'b0;
    w0 = wcnt;
    do_start(16'h0040, 8'd3, 32'h0000_0300);
    wait_done("t5_done");
    check_wlog("t5_wlog", w0, 4, 32'h0000_0300);
    check("t5_err", 64'(err_cnt), 64'd0);

    // Maximum length: 256 beats, counter must not wrap early.
    w0 = wcnt;
    r0 = rlast_cnt;
    do_start(16'h0000, 8'd255, 32'hFFFF_FF00);
    wait_done("t6_done");
    check("t6_wcount", 64'(wcnt - w0), 64'd256);
    check("t6_wdata255", 64'(wlog[w0 + 255]), 64'hFFFF_FFFF);
    check_wlog("t6_wlog", w0, 256, 32'hFFFF_FF00);
    check("t6_rlast", 64'(rlast_cnt - r0), 64'd1);
    check("t6_err", 64'(err_cnt), 64'd0);

    check("no_aw_w_overlap", 64'(ovl_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
